// File: rtl/adc_word_packer.sv
// adc_word_packer: packs 16-bit ADC samples of one capture run into
// 32-bit {second, first} words for the ADC output FIFO (PipeOut 0xA2).
//
// Ports:
//   clk_512k   - block clock (weClk, 512 kHz)
//   rst_n      - asynchronous active-low reset
//   start      - one-cycle pulse, arms (or re-arms) a run, latches nsam
//   nsam       - number of samples in the run
//   smp_valid  - smp_data valid this cycle
//   smp_data   - ADC sample
//   fifo_full  - downstream FIFO cannot take a write this cycle
//   word_wr    - one-cycle FIFO write strobe
//   word_data  - packed word, held while word_wr is low
//   busy       - run in progress (LO, HI, FLUSH, DRAIN)
//   done       - one-cycle pulse at the end of a run
//   word_cnt   - words written in the current or last run
//   ovf_cnt    - pairs dropped under backpressure, saturating

module adc_word_packer #(
   parameter logic [15:0] PAD   = 16'hFFFF,
   parameter int          OVF_W = 16
) (
   input  logic             clk_512k,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      nsam,
   input  logic             smp_valid,
   input  logic [15:0]      smp_data,
   input  logic             fifo_full,
   output logic             word_wr,
   output logic [31:0]      word_data,
   output logic             busy,
   output logic             done,
   output logic [31:0]      word_cnt,
   output logic [OVF_W-1:0] ovf_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LO,
      S_HI,
      S_FLUSH,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [OVF_W-1:0] OVF_ONE = {{(OVF_W-1){1'b0}}, 1'b1};

   state_t      st;
   logic [31:0] rem;
   logic [15:0] lo;
   logic        pend_v;
   logic [31:0] pend_d;

   logic        take;
   logic        rem_last;
   logic        form;
   logic [31:0] form_d;
   logic        ovf_sat;

   // take: a sample is consumed this edge (only while samples remain)
   always_comb begin
      take     = smp_valid && (rem != 32'd0);
      rem_last = (rem == 32'd1);
      ovf_sat  = &ovf_cnt;
      form     = 1'b0;
      form_d   = {PAD, lo};
      if (st == S_HI && take) begin
         form   = 1'b1;
         form_d = {smp_data, lo};
      end else if (st == S_FLUSH) begin
         form   = 1'b1;
      end
   end

   always_ff @(posedge clk_512k or negedge rst_n) begin
      if (!rst_n) begin
         st        <= S_IDLE;
         rem       <= 32'd0;
         lo        <= 16'd0;
         pend_v    <= 1'b0;
         pend_d    <= 32'd0;
         word_wr   <= 1'b0;
         word_data <= 32'd0;
         busy      <= 1'b0;
         done      <= 1'b0;
         word_cnt  <= 32'd0;
         ovf_cnt   <= '0;
      end else begin
         word_wr <= 1'b0;
         done    <= 1'b0;
         if (start) begin
            // Re-arm; an aborted run's pending word is simply forgotten.
            rem      <= nsam;
            word_cnt <= 32'd0;
            ovf_cnt  <= '0;
            pend_v   <= 1'b0;
            if (nsam == 32'd0) begin
               st   <= S_DONE;
               busy <= 1'b0;
               done <= 1'b1;
            end else begin
               st   <= S_LO;
               busy <= 1'b1;
            end
         end else begin
            // Emit stage: pending word drains first, a fresh word
            // then takes its slot; with the slot stuck full, drop.
            if (pend_v) begin
               if (!fifo_full) begin
                  word_wr   <= 1'b1;
                  word_data <= pend_d;
                  word_cnt  <= word_cnt + 32'd1;
                  if (form) begin
                     pend_d <= form_d;
                  end else begin
                     pend_v <= 1'b0;
                  end
               end else if (form && !ovf_sat) begin
                  ovf_cnt <= ovf_cnt + OVF_ONE;
               end
            end else if (form) begin
               if (!fifo_full) begin
                  word_wr   <= 1'b1;
                  word_data <= form_d;
                  word_cnt  <= word_cnt + 32'd1;
               end else begin
                  pend_v <= 1'b1;
                  pend_d <= form_d;
               end
            end

            unique case (st)
               S_IDLE: begin
               end
               S_LO: begin
                  if (take) begin
                     lo  <= smp_data;
                     rem <= rem - 32'd1;
                     st  <= rem_last ? S_FLUSH : S_HI;
                  end
               end
               S_HI: begin
                  if (take) begin
                     rem <= rem - 32'd1;
                     st  <= rem_last ? S_DRAIN : S_LO;
                  end
               end
               S_FLUSH: begin
                  st <= S_DRAIN;
               end
               S_DRAIN: begin
                  // Empty slot means nothing can strobe at this edge,
                  // so done never lands on a write cycle.
                  if (!pend_v) begin
                     st   <= S_DONE;
                     busy <= 1'b0;
                     done <= 1'b1;
                  end
               end
               S_DONE: begin
                  st <= S_IDLE;
               end
               default: begin
                  st   <= S_IDLE;
                  busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_adc_word_packer.sv
// tb_adc_word_packer: directed table-driven bench for adc_word_packer
// plus hand-written abort and mid-run reset sequences.

module tb_adc_word_packer;

   logic        clk_512k;
   logic        rst_n;
   logic        start;
   logic [31:0] nsam;
   logic        smp_valid;
   logic [15:0] smp_data;
   logic        fifo_full;
   logic        word_wr;
   logic [31:0] word_data;
   logic        busy;
   logic        done;
   logic [31:0] word_cnt;
   logic [15:0] ovf_cnt;

   int n_run;
   int n_fail;

   typedef struct {
      logic        st;
      logic [31:0] ns;
      logic        v;
      logic [15:0] d;
      logic        f;
      logic        wr;
      logic [31:0] wd;
      logic        bsy;
      logic        dn;
      logic [31:0] cnt;
      logic [15:0] ovf;
   } vec_t;

   vec_t tbl[$];

   adc_word_packer dut (
      .clk_512k  (clk_512k),
      .rst_n     (rst_n),
      .start     (start),
      .nsam      (nsam),
      .smp_valid (smp_valid),
      .smp_data  (smp_data),
      .fifo_full (fifo_full),
      .word_wr   (word_wr),
      .word_data (word_data),
      .busy      (busy),
      .done      (done),
      .word_cnt  (word_cnt),
      .ovf_cnt   (ovf_cnt)
   );

   initial clk_512k = 1'b0;
   always #5 clk_512k = ~clk_512k;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_512k);
      #1;
   endtask

   task automatic add(input logic st, input logic [31:0] ns,
                      input logic v, input logic [15:0] d,
                      input logic f, input logic wr,
                      input logic [31:0] wd, input logic bsy,
                      input logic dn, input logic [31:0] cnt,
                      input logic [15:0] ovf);
      vec_t r;
      r.st  = st;  r.ns  = ns;  r.v   = v;   r.d = d;
      r.f   = f;   r.wr  = wr;  r.wd  = wd;
      r.bsy = bsy; r.dn  = dn;  r.cnt = cnt; r.ovf = ovf;
      tbl.push_back(r);
   endtask

   task automatic drive(input logic st, input logic [31:0] ns,
                        input logic v, input logic [15:0] d,
                        input logic f);
      start     = st;
      nsam      = ns;
      smp_valid = v;
      smp_data  = d;
      fifo_full = f;
   endtask

   initial begin
      int wr_n;
      int dn_n;
      n_run  = 0;
      n_fail = 0;

      // nsam=4, free-flowing; stray samples after the run are ignored
      add(1, 4, 0, 16'h0000, 0, 0, 32'h0, 1, 0, 0, 0);
      add(0, 0, 1, 16'h0001, 0, 0, 32'h0, 1, 0, 0, 0);
      add(0, 0, 1, 16'h0002, 0, 1, 32'h00020001, 1, 0, 1, 0);
      add(0, 0, 1, 16'h0003, 0, 0, 32'h00020001, 1, 0, 1, 0);
      add(0, 0, 1, 16'h0004, 0, 1, 32'h00040003, 1, 0, 2, 0);
      add(0, 0, 1, 16'h0005, 0, 0, 32'h00040003, 0, 1, 2, 0);
      add(0, 0, 1, 16'h0006, 0, 0, 32'h00040003, 0, 0, 2, 0);
      add(0, 0, 1, 16'h0007, 0, 0, 32'h00040003, 0, 0, 2, 0);
      // nsam=3, odd tail padded with FFFF
      add(1, 3, 0, 16'h0000, 0, 0, 32'h00040003, 1, 0, 0, 0);
      add(0, 0, 1, 16'hA000, 0, 0, 32'h00040003, 1, 0, 0, 0);
      add(0, 0, 1, 16'hA001, 0, 1, 32'hA001A000, 1, 0, 1, 0);
      add(0, 0, 1, 16'hA002, 0, 0, 32'hA001A000, 1, 0, 1, 0);
      add(0, 0, 0, 16'h0000, 0, 1, 32'hFFFFA002, 1, 0, 2, 0);
      add(0, 0, 0, 16'h0000, 0, 0, 32'hFFFFA002, 0, 1, 2, 0);
      add(0, 0, 0, 16'h0000, 0, 0, 32'hFFFFA002, 0, 0, 2, 0);
      // nsam=0: done without busy
      add(1, 0, 0, 16'h0000, 0, 0, 32'hFFFFA002, 0, 1, 0, 0);
      add(0, 0, 0, 16'h0000, 0, 0, 32'hFFFFA002, 0, 0, 0, 0);
      // nsam=8, fifo_full for 6 cycles: pair1 held, pair2 dropped
      add(0, 0, 0, 16'h0000, 1, 0, 32'hFFFFA002, 0, 0, 0, 0);
      add(1, 8, 0, 16'h0000, 1, 0, 32'hFFFFA002, 1, 0, 0, 0);
      add(0, 0, 1, 16'hB001, 1, 0, 32'hFFFFA002, 1, 0, 0, 0);
      add(0, 0, 1, 16'hB002, 1, 0, 32'hFFFFA002, 1, 0, 0, 0);
      add(0, 0, 1, 16'hB003, 1, 0, 32'hFFFFA002, 1, 0, 0, 0);
      add(0, 0, 1, 16'hB004, 1, 0, 32'hFFFFA002, 1, 0, 0, 1);
      add(0, 0, 1, 16'hB005, 0, 1, 32'hB002B001, 1, 0, 1, 1);
      add(0, 0, 1, 16'hB006, 0, 1, 32'hB006B005, 1, 0, 2, 1);
      add(0, 0, 1, 16'hB007, 0, 0, 32'hB006B005, 1, 0, 2, 1);
      add(0, 0, 1, 16'hB008, 0, 1, 32'hB008B007, 1, 0, 3, 1);
      add(0, 0, 0, 16'h0000, 0, 0, 32'hB008B007, 0, 1, 3, 1);
      add(0, 0, 0, 16'h0000, 0, 0, 32'hB008B007, 0, 0, 3, 1);

      rst_n = 1'b0;
      drive(0, 0, 0, 16'h0, 0);
      tick();
      tick();
      chk("rst wr",   {31'd0, word_wr}, 32'd0);
      chk("rst data", word_data,        32'd0);
      chk("rst busy", {31'd0, busy},    32'd0);
      chk("rst done", {31'd0, done},    32'd0);
      chk("rst cnt",  word_cnt,         32'd0);
      chk("rst ovf",  {16'd0, ovf_cnt}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].st, tbl[i].ns, tbl[i].v, tbl[i].d, tbl[i].f);
         tick();
         chk($sformatf("row%0d wr", i), {31'd0, word_wr},
             {31'd0, tbl[i].wr});
         chk($sformatf("row%0d data", i), word_data, tbl[i].wd);
         chk($sformatf("row%0d busy", i), {31'd0, busy},
             {31'd0, tbl[i].bsy});
         chk($sformatf("row%0d done", i), {31'd0, done},
             {31'd0, tbl[i].dn});
         chk($sformatf("row%0d cnt", i), word_cnt, tbl[i].cnt);
         chk($sformatf("row%0d ovf", i), {16'd0, ovf_cnt},
             {16'd0, tbl[i].ovf});
      end

      // abort: re-arm while a word sits in the pending slot
      drive(1, 4, 0, 16'h0, 1);
      tick();
      drive(0, 0, 1, 16'hC001, 1);
      tick();
      drive(0, 0, 1, 16'hC002, 1);
      tick();
      chk("abort held wr", {31'd0, word_wr}, 32'd0);
      drive(1, 2, 0, 16'h0, 0);
      tick();
      chk("abort restart wr",   {31'd0, word_wr}, 32'd0);
      chk("abort restart busy", {31'd0, busy},    32'd1);
      chk("abort restart cnt",  word_cnt,         32'd0);
      wr_n = 0;
      dn_n = 0;
      for (int i = 0; i < 8; i++) begin
         if (i == 0) drive(0, 0, 1, 16'hD001, 0);
         else if (i == 1) drive(0, 0, 1, 16'hD002, 0);
         else drive(0, 0, 0, 16'h0, 0);
         tick();
         if (word_wr) begin
            wr_n++;
            chk("abort word", word_data, 32'hD002D001);
            chk("abort wr/done overlap", {31'd0, done}, 32'd0);
         end
         if (done) begin
            dn_n++;
            chk("abort done after word", wr_n, 1);
         end
      end
      chk("abort writes", wr_n, 1);
      chk("abort dones",  dn_n, 1);
      chk("abort cnt",    word_cnt, 32'd1);
      chk("abort ovf",    {16'd0, ovf_cnt}, 32'd0);

      // reset mid-run, right while a write strobe is up
      drive(1, 4, 0, 16'h0, 0);
      tick();
      drive(0, 0, 1, 16'hE001, 0);
      tick();
      drive(0, 0, 1, 16'hE002, 0);
      tick();
      chk("pre-reset wr", {31'd0, word_wr}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid rst wr",   {31'd0, word_wr}, 32'd0);
      chk("mid rst data", word_data,        32'd0);
      chk("mid rst busy", {31'd0, busy},    32'd0);
      chk("mid rst done", {31'd0, done},    32'd0);
      chk("mid rst cnt",  word_cnt,         32'd0);
      chk("mid rst ovf",  {16'd0, ovf_cnt}, 32'd0);
      drive(0, 0, 1, 16'hE003, 0);
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 16'hE004 + 16'(i), 0);
         tick();
         chk($sformatf("post rst wr%0d", i), {31'd0, word_wr}, 32'd0);
         chk($sformatf("post rst busy%0d", i), {31'd0, busy}, 32'd0);
      end

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
